imem_fetch_buffer: RTL and testbench

Parametrised instruction memory for the fetch stage, successor to the single-port 64-word instruction store. Fetch requests use a valid/ready handshake, read latency is configurable, and a response buffer absorbs decode-side stalls without losing fetched words. The block adds a dedicated load port, PC range and alignment fault reporting, a flush that kills in-flight fetches, and a fetch counter. It sits between the PC/fetch logic and the fetch-decode pipeline register.

---
 rtl/imem_fetch_buffer.sv | 165 ++++++++++++++++
 tb/tb_imem_fetch_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_buffer.sv
// Fetch-stage instruction memory: valid/ready requests, 1- or 2-cycle read latency,
// a response FIFO that absorbs decode stalls, range/alignment faults, flush and a load port.
module imem_fetch_buffer #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 64,
  parameter int                    READ_LATENCY = 1,
  parameter logic [31:0]           BASE_ADDR    = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [31:0]              i_req_pc,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_instr,
  output logic [31:0]              o_rsp_pc,
  output logic [1:0]               o_rsp_fault,
  input  logic                     i_flush,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0]    i_load_data,
  output logic [31:0]              o_fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FD = READ_LATENCY + 1;
  localparam int PW = (FD > 2) ? $clog2(FD) : 1;
  localparam int CW = $clog2(FD + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           pc;
    logic [1:0]            fault;
  } entry_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  entry_t                r_fifo [FD];
  logic [PW-1:0]         r_rdPtr;
  logic [PW-1:0]         r_wrPtr;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_lastPc;
  logic [31:0]           r_fetchCount;

  logic [31:0]           w_offset;
  logic [AW-1:0]         w_idx;
  logic [1:0]            w_fault;
  entry_t                w_reqEntry;
  entry_t                w_head;
  entry_t                w_pushEntry;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_accept;
  logic [CW-1:0]         w_inflight;
  logic [CW-1:0]         w_creditsLeft;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request decode: faulting requests never touch the memory array
  always_comb begin
    w_offset         = i_req_pc - BASE_ADDR;
    w_idx            = w_offset[AW+1:2];
    w_fault          = {(w_offset >= 32'(DEPTH * 4)), (i_req_pc[1:0] != 2'b00)};
    w_reqEntry       = '0;
    w_reqEntry.pc    = i_req_pc;
    w_reqEntry.fault = w_fault;
    w_reqEntry.instr = (w_fault != 2'b00) ? NOP_INSTR : r_mem[w_idx];
  end

  // Load port is read-first: the combinational read above sees the pre-write word
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  assign o_rsp_valid   = (r_count != '0);
  assign w_head        = r_fifo[r_rdPtr];
  assign w_pop         = o_rsp_valid && i_rsp_ready && !i_flush;
  assign w_creditsLeft = r_count + w_inflight - CW'(w_pop);
  assign o_req_ready   = i_rst_n && !i_flush && (w_creditsLeft < CW'(FD));
  assign w_accept      = i_req_valid && o_req_ready;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign w_push      = w_accept;
      assign w_pushEntry = w_reqEntry;
      assign w_inflight  = '0;
    end else begin : g_lat2
      logic   r_stageValid;
      entry_t r_stageEntry;

      // One registered read stage; a flush or reset kills whatever is in it
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
          r_stageValid <= 1'b0;
        end else begin
          r_stageValid <= w_accept;
        end
        if (w_accept) begin
          r_stageEntry <= w_reqEntry;
        end
      end

      assign w_push      = r_stageValid;
      assign w_pushEntry = r_stageEntry;
      assign w_inflight  = CW'(r_stageValid);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_push) begin
      r_fifo[r_wrPtr] <= w_pushEntry;
    end
  end

  // Credit accounting guarantees a push never lands on a full FIFO
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetchCount <= '0;
      r_lastPc     <= '0;
    end else begin
      if (w_pop) begin
        r_fetchCount <= r_fetchCount + 32'd1;
      end
      if (o_rsp_valid) begin
        r_lastPc <= w_head.pc;
      end
    end
  end

  // An empty FIFO presents a NOP and keeps showing the last PC seen at the head
  always_comb begin
    o_rsp_instr = NOP_INSTR;
    o_rsp_fault = 2'b00;
    o_rsp_pc    = r_lastPc;
    if (o_rsp_valid) begin
      o_rsp_instr = w_head.instr;
      o_rsp_fault = w_head.fault;
      o_rsp_pc    = w_head.pc;
    end
  end

  assign o_fetch_count = r_fetchCount;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed bench for imem_fetch_buffer at READ_LATENCY=2: reset, streaming, stalls,
// faults, flush, load collisions and reset in the middle of a stream.
module tb_imem_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqPc;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspInstr;
  logic [31:0] rspPc;
  logic [1:0]  rspFault;
  logic        flush;
  logic        loadEn;
  logic [5:0]  loadAddr;
  logic [31:0] loadData;
  logic [31:0] fetchCount;

  int tests    = 0;
  int failures = 0;

  imem_fetch_buffer #(
    .DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(2),
    .BASE_ADDR(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_pc(reqPc),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_instr(rspInstr),
    .o_rsp_pc(rspPc), .o_rsp_fault(rspFault), .i_flush(flush),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData),
    .o_fetch_count(fetchCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc);
    reqValid = v;
    reqPc    = pc;
  endtask

  task automatic test_reset();
    step();
    step();
    tests++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b exp 0", rspValid); end
    tests++; if (rspInstr !== NOP) begin failures++; $display("[TB] FAIL reset_instr got %h exp %h", rspInstr, NOP); end
    tests++; if (rspPc !== 32'd0) begin failures++; $display("[TB] FAIL reset_pc got %h exp 0", rspPc); end
    tests++; if (rspFault !== 2'b00) begin failures++; $display("[TB] FAIL reset_fault got %b exp 00", rspFault); end
    tests++; if (fetchCount !== 32'd0) begin failures++; $display("[TB] FAIL reset_count got %0d exp 0", fetchCount); end
    tests++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_low got %b exp 0", reqReady); end
    rstN = 1'b1;
    #1;
    tests++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_high got %b exp 1", reqReady); end
  endtask

  task automatic test_back_to_back();
    logic expValid;
    for (int i = 0; i < 4; i++) begin
      loadEn = 1'b1; loadAddr = 6'(i); loadData = W0 + 32'(i);
      step();
    end
    loadEn   = 1'b0;
    rspReady = 1'b1;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(t < 4, 32'(4 * t));
      #1;
      if (t < 4) begin
        tests++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready t=%0d got %b exp 1", t, reqReady); end
      end
      step();
      expValid = (t >= 1 && t <= 4);
      tests++; if (rspValid !== expValid) begin failures++; $display("[TB] FAIL b2b_valid t=%0d got %b exp %b", t, rspValid, expValid); end
      if (expValid) begin
        tests++; if (rspInstr !== W0 + 32'(t - 1)) begin failures++; $display("[TB] FAIL b2b_instr t=%0d got %h exp %h", t, rspInstr, W0 + 32'(t - 1)); end
        tests++; if (rspPc !== 32'(4 * (t - 1))) begin failures++; $display("[TB] FAIL b2b_pc t=%0d got %h exp %h", t, rspPc, 32'(4 * (t - 1))); end
      end
    end
    applyStimulus(1'b0, 32'd0);
    tests++; if (fetchCount !== 32'd4) begin failures++; $display("[TB] FAIL b2b_count got %0d exp 4", fetchCount); end
  endtask

  task automatic test_stall();
    logic [31:0] nextPc;
    logic        expReady;
    nextPc   = 32'd0;
    rspReady = 1'b0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, nextPc);
      #1;
      expReady = (t < 3);
      tests++; if (reqReady !== expReady) begin failures++; $display("[TB] FAIL stall_ready t=%0d got %b exp %b", t, reqReady, expReady); end
      if (reqReady === 1'b1) nextPc = nextPc + 32'd4;
      step();
    end
    applyStimulus(1'b0, 32'd0);
    #1;
    tests++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL stall_full_ready got %b exp 0", reqReady); end
    tests++; if (rspValid !== 1'b1 || rspPc !== 32'd0 || rspInstr !== W0) begin
      failures++; $display("[TB] FAIL stall_hold got v=%b pc=%h instr=%h exp v=1 pc=0 instr=%h", rspValid, rspPc, rspInstr, W0);
    end
    rspReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (rspValid !== 1'b1 || rspPc !== 32'(4 * k) || rspInstr !== W0 + 32'(k)) begin
        failures++; $display("[TB] FAIL stall_drain k=%0d got v=%b pc=%h instr=%h exp pc=%h instr=%h", k, rspValid, rspPc, rspInstr, 32'(4 * k), W0 + 32'(k));
      end
      step();
    end
    tests++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL stall_empty got %b exp 0", rspValid); end
    tests++; if (fetchCount !== 32'd7) begin failures++; $display("[TB] FAIL stall_count got %0d exp 7", fetchCount); end
  endtask

  task automatic test_faults();
    logic [31:0] pcs [4];
    logic [31:0] instrs [4];
    logic [1:0]  faults [4];
    logic        expValid;
    int          j;
    pcs    = '{32'd4, 32'd6, 32'd256, 32'd8};
    instrs = '{W0 + 32'd1, NOP, NOP, W0 + 32'd2};
    faults = '{2'b00, 2'b01, 2'b10, 2'b00};
    rspReady = 1'b1;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(t < 4, (t < 4) ? pcs[t] : 32'd0);
      step();
      expValid = (t >= 1 && t <= 4);
      tests++; if (rspValid !== expValid) begin failures++; $display("[TB] FAIL fault_valid t=%0d got %b exp %b", t, rspValid, expValid); end
      if (expValid) begin
        j = t - 1;
        tests++; if (rspFault !== faults[j] || rspInstr !== instrs[j] || rspPc !== pcs[j]) begin
          failures++; $display("[TB] FAIL fault_rsp j=%0d got f=%b instr=%h pc=%h exp f=%b instr=%h pc=%h", j, rspFault, rspInstr, rspPc, faults[j], instrs[j], pcs[j]);
        end
      end
    end
    applyStimulus(1'b0, 32'd0);
    tests++; if (fetchCount !== 32'd11) begin failures++; $display("[TB] FAIL fault_count got %0d exp 11", fetchCount); end
  endtask

  task automatic test_flush();
    rspReady = 1'b1;
    applyStimulus(1'b1, 32'd0);
    step();
    applyStimulus(1'b1, 32'd4);
    step();
    applyStimulus(1'b1, 32'd8);
    flush = 1'b1;
    #1;
    tests++; if (reqReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready got %b exp 0", reqReady); end
    tests++; if (rspValid !== 1'b1) begin failures++; $display("[TB] FAIL flush_head got %b exp 1", rspValid); end
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0);
    tests++; if (rspValid !== 1'b0 || rspInstr !== NOP) begin failures++; $display("[TB] FAIL flush_empty got v=%b instr=%h exp v=0 instr=%h", rspValid, rspInstr, NOP); end
    for (int t = 0; t < 3; t++) begin
      step();
      tests++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_stale t=%0d got %b exp 0", t, rspValid); end
    end
    tests++; if (fetchCount !== 32'd11) begin failures++; $display("[TB] FAIL flush_count got %0d exp 11", fetchCount); end
    applyStimulus(1'b1, 32'd12);
    #1;
    tests++; if (reqReady !== 1'b1) begin failures++; $display("[TB] FAIL flush_after_ready got %b exp 1", reqReady); end
    step();
    applyStimulus(1'b0, 32'd0);
    step();
    tests++; if (rspValid !== 1'b1 || rspPc !== 32'd12 || rspInstr !== W0 + 32'd3) begin
      failures++; $display("[TB] FAIL flush_after_rsp got v=%b pc=%h instr=%h exp v=1 pc=0000000c instr=%h", rspValid, rspPc, rspInstr, W0 + 32'd3);
    end
    step();
    tests++; if (fetchCount !== 32'd12) begin failures++; $display("[TB] FAIL flush_after_count got %0d exp 12", fetchCount); end
  endtask

  task automatic test_load_collision();
    rspReady = 1'b1;
    loadEn = 1'b1; loadAddr = 6'd5; loadData = 32'h5555_5555;
    applyStimulus(1'b0, 32'd0);
    step();
    loadData = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'd20);
    step();
    loadEn = 1'b0;
    applyStimulus(1'b1, 32'd20);
    step();
    applyStimulus(1'b0, 32'd0);
    tests++; if (rspValid !== 1'b1 || rspInstr !== 32'h5555_5555 || rspPc !== 32'd20) begin
      failures++; $display("[TB] FAIL collide_old got v=%b instr=%h pc=%h exp v=1 instr=55555555 pc=00000014", rspValid, rspInstr, rspPc);
    end
    step();
    tests++; if (rspValid !== 1'b1 || rspInstr !== 32'hDEAD_BEEF || rspPc !== 32'd20) begin
      failures++; $display("[TB] FAIL collide_new got v=%b instr=%h pc=%h exp v=1 instr=deadbeef pc=00000014", rspValid, rspInstr, rspPc);
    end
    step();
    tests++; if (fetchCount !== 32'd14) begin failures++; $display("[TB] FAIL collide_count got %0d exp 14", fetchCount); end
  endtask

  task automatic test_reset_mid_stream();
    loadEn = 1'b1; loadAddr = 6'd9; loadData = 32'h0000_0099;
    applyStimulus(1'b0, 32'd0);
    step();
    loadEn   = 1'b0;
    rspReady = 1'b0;
    applyStimulus(1'b1, 32'd36);
    step();
    applyStimulus(1'b1, 32'd20);
    step();
    applyStimulus(1'b0, 32'd0);
    step();
    tests++; if (rspValid !== 1'b1 || rspPc !== 32'd36) begin failures++; $display("[TB] FAIL rst_mid_buffered got v=%b pc=%h exp v=1 pc=00000024", rspValid, rspPc); end
    rstN = 1'b0;
    loadEn = 1'b1; loadAddr = 6'd9; loadData = 32'hBAD0_BAD0;
    step();
    tests++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got %b exp 0", rspValid); end
    tests++; if (fetchCount !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_count got %0d exp 0", fetchCount); end
    tests++; if (rspInstr !== NOP || rspPc !== 32'd0) begin failures++; $display("[TB] FAIL rst_mid_outputs got instr=%h pc=%h exp instr=%h pc=0", rspInstr, rspPc, NOP); end
    rstN = 1'b1;
    loadEn = 1'b0;
    rspReady = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      tests++; if (rspValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_stale t=%0d got %b exp 0", t, rspValid); end
    end
    applyStimulus(1'b1, 32'd36);
    step();
    applyStimulus(1'b1, 32'd20);
    step();
    applyStimulus(1'b0, 32'd0);
    tests++; if (rspValid !== 1'b1 || rspInstr !== 32'h0000_0099 || rspPc !== 32'd36) begin
      failures++; $display("[TB] FAIL rst_mid_mem9 got v=%b instr=%h pc=%h exp v=1 instr=00000099 pc=00000024", rspValid, rspInstr, rspPc);
    end
    step();
    tests++; if (rspValid !== 1'b1 || rspInstr !== 32'hDEAD_BEEF || rspPc !== 32'd20) begin
      failures++; $display("[TB] FAIL rst_mid_mem5 got v=%b instr=%h pc=%h exp v=1 instr=deadbeef pc=00000014", rspValid, rspInstr, rspPc);
    end
    step();
    tests++; if (fetchCount !== 32'd2) begin failures++; $display("[TB] FAIL rst_mid_count_after got %0d exp 2", fetchCount); end
  endtask

  initial begin
    rstN     = 1'b0;
    reqValid = 1'b0;
    reqPc    = 32'd0;
    rspReady = 1'b0;
    flush    = 1'b0;
    loadEn   = 1'b0;
    loadAddr = 6'd0;
    loadData = 32'd0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_faults();
    test_flush();
    test_load_collision();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
